// File: rtl/alu_arbiter_if.sv
// Request/response bus of alu_arbiter: two requester channels, one response
// channel and the per-requester completion counters.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_y;
    logic        rsp_zero;
    logic        rsp_err;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err, cnt0, cnt1
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err, cnt0, cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one combinational ALU through an IDLE -> EXEC -> RESP
// handshake FSM with round-robin or fixed-priority grant.
module alu #(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] A,
    input  logic signed [DATA_W-1:0] B,
    input  logic        [3:0]        ALUCtrl,
    output logic signed [DATA_W-1:0] Y,
    output logic                     ZERO
);
    always_comb begin
        Y = '0;
        case (ALUCtrl)
            4'b0000: Y = A & B;
            4'b0001: Y = A | B;
            4'b0010: Y = A + B;
            4'b0110: Y = A - B;
            4'b0111: Y = {{(DATA_W-1){1'b0}}, (A < B)};
            default: Y = '0;
        endcase
    end

    assign ZERO = (Y == '0);
endmodule

module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    state_t state_nxt;

    logic        last_gnt;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        rsp_hs;

    logic [3:0]               op_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;
    logic                     id_p0;

    logic signed [DATA_W-1:0] alu_y;
    logic                     alu_zero;

    logic signed [DATA_W-1:0] y_p1;
    logic                     zero_p1;
    logic                     err_p1;
    logic                     id_p1;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    // A tie goes to whichever requester did not win last time (round-robin only).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            if (RR_EN && !last_gnt) gnt1 = 1'b1;
            else                    gnt0 = 1'b1;
        end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
        end
    end

    assign bus.req0_ready = (state == IDLE) && !rst && gnt0;
    assign bus.req1_ready = (state == IDLE) && !rst && gnt1;
    assign accept = (bus.req0_valid && bus.req0_ready) ||
                    (bus.req1_valid && bus.req1_ready);
    assign rsp_hs = (state == RESP) && bus.rsp_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Stage p0: capture the granted request; the ALU sees only these registers.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= bus.req1_ready ? bus.req1_op : bus.req0_op;
            a_p0  <= bus.req1_ready ? bus.req1_a  : bus.req0_a;
            b_p0  <= bus.req1_ready ? bus.req1_b  : bus.req0_b;
            id_p0 <= bus.req1_ready;
        end
    end

    alu #(.DATA_W(DATA_W)) u_alu (
        .A       (a_p0),
        .B       (b_p0),
        .ALUCtrl (op_p0),
        .Y       (alu_y),
        .ZERO    (alu_zero)
    );

    // Stage p1: register the ALU result at the end of EXEC and hold it through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
            y_p1     <= '0;
            zero_p1  <= 1'b0;
            err_p1   <= 1'b0;
            id_p1    <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
        end else begin
            if (accept) last_gnt <= bus.req1_ready;
            if (state == EXEC) begin
                y_p1    <= op_legal(op_p0) ? alu_y : '0;
                zero_p1 <= op_legal(op_p0) ? alu_zero : 1'b1;
                err_p1  <= !op_legal(op_p0);
                id_p1   <= id_p0;
            end
            if (rsp_hs) begin
                if (id_p1) cnt1 <= cnt1 + 1'b1;
                else       cnt0 <= cnt0 + 1'b1;
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = id_p1;
    assign bus.rsp_y     = y_p1;
    assign bus.rsp_zero  = zero_p1;
    assign bus.rsp_err   = err_p1;
    assign bus.cnt0      = cnt0;
    assign bus.cnt1      = cnt1;
endmodule
